// File: rtl/gelato_split_table_if.sv
// I-Decode <-> split table request/response bus.
// Request side is handshaked; the response side carries a consumer stall.
interface gelato_split_table_if #(
    parameter int NUM_WARPS   = 4,
    parameter int NUM_THREADS = 32,
    parameter int ADDR_WIDTH  = 32
);
    localparam int WW = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;

    logic                   req_valid;
    logic                   req_ready;
    logic [1:0]             req_op;
    logic [WW-1:0]          req_warp_num;
    logic [NUM_THREADS-1:0] req_taken_mask;
    logic [ADDR_WIDTH-1:0]  req_taken_pc;
    logic [ADDR_WIDTH-1:0]  req_fallthru_pc;
    logic [ADDR_WIDTH-1:0]  req_rpc;
    logic                   rsp_valid;
    logic [WW-1:0]          rsp_warp_num;
    logic [ADDR_WIDTH-1:0]  rsp_pc;
    logic [NUM_THREADS-1:0] rsp_thread_mask;
    logic                   rsp_error;
    logic                   stall;

    modport master (
        output req_valid, req_op, req_warp_num, req_taken_mask, req_taken_pc,
               req_fallthru_pc, req_rpc, stall,
        input  req_ready, rsp_valid, rsp_warp_num, rsp_pc, rsp_thread_mask, rsp_error
    );

    modport slave (
        input  req_valid, req_op, req_warp_num, req_taken_mask, req_taken_pc,
               req_fallthru_pc, req_rpc, stall,
        output req_ready, rsp_valid, rsp_warp_num, rsp_pc, rsp_thread_mask, rsp_error
    );
endinterface

// File: rtl/gelato_split_table.sv
// Per-warp SIMT divergence stack: SPLIT pushes {rpc, ft, taken}, JOIN pops to the next path.
// Optional macro GELATO_SPLIT_TABLE_PERF_EN adds divergence count and peak depth outputs.

module gelato_split_table_warp #(
    parameter int NUM_THREADS = 32,
    parameter int DEPTH       = 8,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [ADDR_WIDTH-1:0]      push_pc,
    input  logic [NUM_THREADS-1:0]     push_mask,
    input  logic                       push_rc,
    output logic [$clog2(DEPTH+1)-1:0] sp,
    output logic [NUM_THREADS-1:0]     am,
    output logic [ADDR_WIDTH-1:0]      tos_pc,
    output logic [NUM_THREADS-1:0]     tos_mask,
    output logic [ADDR_WIDTH-1:0]      nos_pc,
    output logic [NUM_THREADS-1:0]     nos_mask,
    output logic                       nos_rc
);
    localparam int SPW = $clog2(DEPTH + 1);
    localparam int IW  = $clog2(DEPTH);

    logic [ADDR_WIDTH-1:0]  pc_mem   [DEPTH];
    logic [NUM_THREADS-1:0] mask_mem [DEPTH];
    logic                   rc_mem   [DEPTH];
    logic [SPW-1:0]         tos_idx, nos_idx;

    assign tos_idx = sp - SPW'(1);
    assign nos_idx = sp - SPW'(2);

    // Push and pop are never requested together; the caller's error paths keep sp in range.
    always_ff @(posedge clk) begin
        if (rst)       sp <= '0;
        else if (push) sp <= sp + SPW'(1);
        else if (pop)  sp <= sp - SPW'(1);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[sp[IW-1:0]]   <= push_pc;
            mask_mem[sp[IW-1:0]] <= push_mask;
            rc_mem[sp[IW-1:0]]   <= push_rc;
        end
    end

    assign tos_pc   = pc_mem[tos_idx[IW-1:0]];
    assign tos_mask = mask_mem[tos_idx[IW-1:0]];
    assign nos_pc   = pc_mem[nos_idx[IW-1:0]];
    assign nos_mask = mask_mem[nos_idx[IW-1:0]];
    assign nos_rc   = rc_mem[nos_idx[IW-1:0]];
    assign am       = (sp != '0) ? tos_mask : '1;
endmodule

module gelato_split_table #(
    parameter int NUM_WARPS   = 4,
    parameter int NUM_THREADS = 32,
    parameter int DEPTH       = 8,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    gelato_split_table_if.slave    bus,
    input  logic [((NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1)-1:0] q_warp_num,
    output logic [NUM_THREADS-1:0] q_thread_mask
`ifdef GELATO_SPLIT_TABLE_PERF_EN
    ,
    output logic [31:0]                  perf_diverge_cnt,
    output logic [$clog2(DEPTH+1)-1:0]   perf_peak_depth
`endif
);
    localparam int WW  = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
    localparam int SPW = $clog2(DEPTH + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PUSH_FT = 3'd1;
    localparam logic [2:0] S_PUSH_TK = 3'd2;
    localparam logic [2:0] S_POP_RC  = 3'd3;
    localparam logic [2:0] S_RESP    = 3'd4;

    localparam logic [1:0] OP_SPLIT = 2'b01;
    localparam logic [1:0] OP_JOIN  = 2'b10;

    logic [2:0]             state;
    logic [WW-1:0]          cur_warp;
    logic [NUM_THREADS-1:0] t_l, am_l;
    logic [ADDR_WIDTH-1:0]  tk_l, ft_l;

    logic                   rsp_valid_q, rsp_error_q;
    logic [WW-1:0]          rsp_warp_q;
    logic [ADDR_WIDTH-1:0]  rsp_pc_q;
    logic [NUM_THREADS-1:0] rsp_mask_q;

    logic [NUM_WARPS-1:0]                  w_push, w_pop, w_nos_rc;
    logic [NUM_WARPS-1:0][SPW-1:0]         w_sp;
    logic [NUM_WARPS-1:0][NUM_THREADS-1:0] w_am, w_tos_mask, w_nos_mask;
    logic [NUM_WARPS-1:0][ADDR_WIDTH-1:0]  w_tos_pc, w_nos_pc;

    logic                   push_en, pop_en, push_rc;
    logic [WW-1:0]          op_warp;
    logic [ADDR_WIDTH-1:0]  push_pc;
    logic [NUM_THREADS-1:0] push_mask;

    logic                   accept, is_split, is_join, uniform, ovf, div_go;
    logic [SPW-1:0]         acc_sp;
    logic [NUM_THREADS-1:0] acc_am, acc_t;

    for (genvar g = 0; g < NUM_WARPS; g++) begin : g_warp
        gelato_split_table_warp #(
            .NUM_THREADS (NUM_THREADS),
            .DEPTH       (DEPTH),
            .ADDR_WIDTH  (ADDR_WIDTH)
        ) u_warp (
            .clk       (clk),
            .rst       (rst),
            .push      (w_push[g]),
            .pop       (w_pop[g]),
            .push_pc   (push_pc),
            .push_mask (push_mask),
            .push_rc   (push_rc),
            .sp        (w_sp[g]),
            .am        (w_am[g]),
            .tos_pc    (w_tos_pc[g]),
            .tos_mask  (w_tos_mask[g]),
            .nos_pc    (w_nos_pc[g]),
            .nos_mask  (w_nos_mask[g]),
            .nos_rc    (w_nos_rc[g])
        );
    end

    assign bus.req_ready = !rst && (state == S_IDLE) && !(rsp_valid_q && bus.stall);
    assign accept        = bus.req_valid && bus.req_ready;
    assign is_split      = (bus.req_op == OP_SPLIT);
    assign is_join       = (bus.req_op == OP_JOIN);

    assign acc_sp  = w_sp[bus.req_warp_num];
    assign acc_am  = w_am[bus.req_warp_num];
    assign acc_t   = bus.req_taken_mask & acc_am;
    assign uniform = (acc_t == '0) || (acc_t == acc_am);
    // A divergent split needs three free slots: rc, fall-through and taken.
    assign ovf     = (acc_sp > SPW'(DEPTH - 3));
    assign div_go  = accept && is_split && !uniform && !ovf;

    always_comb begin
        push_en   = 1'b0;
        pop_en    = 1'b0;
        push_rc   = 1'b0;
        push_pc   = '0;
        push_mask = '0;
        op_warp   = cur_warp;
        case (state)
            S_IDLE: begin
                op_warp = bus.req_warp_num;
                if (div_go) begin
                    push_en   = 1'b1;
                    push_pc   = bus.req_rpc;
                    push_mask = acc_am;
                    push_rc   = 1'b1;
                end
                if (accept && is_join && acc_sp != '0) pop_en = 1'b1;
            end
            S_PUSH_FT: begin
                push_en   = 1'b1;
                push_pc   = ft_l;
                push_mask = am_l & ~t_l;
            end
            S_PUSH_TK: begin
                push_en   = 1'b1;
                push_pc   = tk_l;
                push_mask = t_l;
            end
            S_POP_RC: pop_en = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        w_push          = '0;
        w_pop           = '0;
        w_push[op_warp] = push_en;
        w_pop[op_warp]  = pop_en;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cur_warp    <= '0;
            t_l         <= '0;
            am_l        <= '0;
            tk_l        <= '0;
            ft_l        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_warp_q  <= '0;
            rsp_pc_q    <= '0;
            rsp_mask_q  <= '0;
        end else begin
            case (state)
                S_IDLE: if (accept && (is_split || is_join)) begin
                    cur_warp   <= bus.req_warp_num;
                    t_l        <= acc_t;
                    am_l       <= acc_am;
                    tk_l       <= bus.req_taken_pc;
                    ft_l       <= bus.req_fallthru_pc;
                    rsp_warp_q <= bus.req_warp_num;
                    if (is_split) begin
                        if (div_go) state <= S_PUSH_FT;
                        else begin
                            state       <= S_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_error_q <= !uniform;
                            rsp_mask_q  <= acc_am;
                            rsp_pc_q    <= (uniform && acc_t == acc_am) ? bus.req_taken_pc
                                                                        : bus.req_fallthru_pc;
                        end
                    end else if (acc_sp >= SPW'(2) && w_nos_rc[bus.req_warp_num]) begin
                        state <= S_POP_RC;
                    end else begin
                        // Popping the last entry (or an empty stack) falls back to fallthru/all-ones.
                        state       <= S_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_error_q <= (acc_sp == '0);
                        rsp_pc_q    <= (acc_sp >= SPW'(2)) ? w_nos_pc[bus.req_warp_num]
                                                           : bus.req_fallthru_pc;
                        rsp_mask_q  <= (acc_sp >= SPW'(2)) ? w_nos_mask[bus.req_warp_num] : '1;
                    end
                end
                S_PUSH_FT: state <= S_PUSH_TK;
                S_PUSH_TK: begin
                    state       <= S_RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_error_q <= 1'b0;
                    rsp_pc_q    <= tk_l;
                    rsp_mask_q  <= t_l;
                end
                S_POP_RC: begin
                    state       <= S_RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_error_q <= 1'b0;
                    rsp_pc_q    <= w_tos_pc[cur_warp];
                    rsp_mask_q  <= w_tos_mask[cur_warp];
                end
                S_RESP: if (!bus.stall) begin
                    state       <= S_IDLE;
                    rsp_valid_q <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.rsp_valid       = rsp_valid_q;
    assign bus.rsp_error       = rsp_error_q;
    assign bus.rsp_warp_num    = rsp_warp_q;
    assign bus.rsp_pc          = rsp_pc_q;
    assign bus.rsp_thread_mask = rsp_mask_q;
    assign q_thread_mask       = w_am[q_warp_num];

`ifdef GELATO_SPLIT_TABLE_PERF_EN
    logic [SPW-1:0] max_sp;

    always_comb begin
        max_sp = '0;
        for (int i = 0; i < NUM_WARPS; i++)
            if (w_sp[i] > max_sp) max_sp = w_sp[i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_diverge_cnt <= '0;
            perf_peak_depth  <= '0;
        end else begin
            if (div_go && perf_diverge_cnt != '1) perf_diverge_cnt <= perf_diverge_cnt + 32'd1;
            if (max_sp > perf_peak_depth)         perf_peak_depth  <= max_sp;
        end
    end
`endif
endmodule

// File: doc/gelato_split_table.md
Name: gelato_split_table

Overview:
- Per-warp SIMT divergence stack (split table) serving I-Decode.
- Parametrised successor of the single-lookup decode/split-table link. It adds:
  - handshaked SPLIT/JOIN operations;
  - multi-cycle push/pop sequencing;
  - reconvergence entries;
  - overflow/underflow detection;
  - configurable warp count, thread count and depth.
- Sits between I-Decode and the warp scheduler. It returns the next PC and active thread mask after each divergence event.

Parameters:
- NUM_WARPS, 4, warps tracked; one independent stack each.
- NUM_THREADS, 32, threads per warp; this is the mask width.
- DEPTH, 8, entries per warp stack; must be >= 3.
- ADDR_WIDTH, 32, PC width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  operation request.
- req_ready  out  1  table can accept a request.
- req_op  in  2  00 NOP, 01 SPLIT, 10 JOIN, 11 reserved (treated as NOP).
- req_warp_num  in  $clog2(NUM_WARPS)  target warp.
- req_taken_mask  in  NUM_THREADS  threads taking the branch (SPLIT).
- req_taken_pc  in  ADDR_WIDTH  branch target (SPLIT).
- req_fallthru_pc  in  ADDR_WIDTH  not-taken PC (SPLIT); fallback PC on JOIN error.
- req_rpc  in  ADDR_WIDTH  reconvergence PC (SPLIT).
- rsp_valid  out  1  response available.
- rsp_warp_num  out  $clog2(NUM_WARPS)  warp of response.
- rsp_pc  out  ADDR_WIDTH  PC the warp continues at.
- rsp_thread_mask  out  NUM_THREADS  active mask from here on.
- rsp_error  out  1  overflow (SPLIT) or underflow (JOIN).
- stall  in  1  consumer not ready; holds rsp_* stable.
- q_warp_num  in  $clog2(NUM_WARPS)  combinational query warp.
- q_thread_mask  out  NUM_THREADS  current active mask of q_warp_num.

Behaviour:
- **Storage and active mask**
  - Each stack entry is {pc, mask, is_rc}. Each warp has a stack pointer sp of width $clog2(DEPTH+1).
  - Active mask of warp w (AM) = TOS mask if sp>0, else all-ones.
  - q_thread_mask = AM of q_warp_num, purely combinational. It reflects only committed writes, never in-flight ones.
- **Reset (rst=1, any state, including mid-sequence)**
  - All sp=0, FSM to IDLE.
  - rsp_valid=0, rsp_error=0, rsp_pc=0, rsp_thread_mask=0, rsp_warp_num=0, req_ready=0 during reset.
  - Entry contents are don't-care.
- **Handshake**
  - req_ready=1 only in IDLE and not (rsp_valid && stall).
  - A request is accepted when req_valid && req_ready. Request fields are latched at acceptance.
  - rsp_valid pulses for one cycle. While stall=1 it stays high and all rsp_* hold. The response retires on the first cycle with stall=0.
- **FSM states:** IDLE, PUSH_FT, PUSH_TK, POP_RC, RESP.
- **NOP:** accepted, no state change, no response.
- **SPLIT, uniform** (T = taken_mask & AM; T==0 or T==AM)
  - No push. IDLE->RESP; rsp_valid the cycle after acceptance.
  - rsp_pc = taken_pc if T==AM else fallthru_pc. rsp_thread_mask = AM.
- **SPLIT, divergent**
  - If sp+3 > DEPTH: no push, RESP with rsp_error=1, rsp_pc=fallthru_pc, mask=AM.
  - Otherwise:
    - acceptance cycle: push {rpc, AM, 1};
    - PUSH_FT: push {fallthru_pc, AM&~T, 0};
    - PUSH_TK: push {taken_pc, T, 0};
    - RESP: rsp_pc=taken_pc, mask=T.
  - rsp_valid arrives 3 cycles after acceptance.
- **JOIN**
  - If sp==0: RESP with rsp_error=1, pc=fallthru_pc, mask=all-ones.
  - Otherwise pop on the acceptance cycle. If the new TOS has is_rc=1, go to POP_RC and pop it too; rsp_pc = its pc, mask = its mask (2-cycle latency). Otherwise rsp_pc/mask = new TOS pc/mask (1-cycle latency).
- **Independence:** warps are independent. An operation on warp A never alters warp B's sp or entries.
- **Arithmetic:** sp arithmetic never wraps. Underflow and overflow are prevented by the error paths above.

Optional Feature:
- Macro: GELATO_SPLIT_TABLE_PERF_EN.
- When defined, add two outputs:
  - perf_diverge_cnt (32-bit): increments once per accepted divergent non-error SPLIT, saturating at 2^32-1.
  - perf_peak_depth ($clog2(DEPTH+1)): maximum sp reached by any warp since reset.
- Both reset to 0.
- When undefined, neither port nor its logic exists; all other behaviour is identical.

Test Plan:
- Bench uses NUM_THREADS=8, DEPTH=6.
- SPLIT w0 with mask=8'h0F, taken=0x100, ft=0x200, rpc=0x300 -> rsp 3 cycles later: pc=0x100, mask=8'h0F. sp=3, q_thread_mask(w0)=8'h0F.
- JOIN w0 twice after the above -> 1st: pc=0x200, mask=8'hF0 (1-cycle). 2nd: pc=0x300, mask=8'hFF (2-cycle), sp=0.
- SPLIT with taken_mask=8'hFF, then 8'h00 -> no push, pcs taken_pc then fallthru_pc, mask=8'hFF, sp stays 0.
- Two nested divergent SPLITs on w1 (sp=6), then a third -> rsp_error=1, sp stays 6. JOIN on empty w2 -> rsp_error=1, mask=8'hFF.
- Hold stall=1 for 4 cycles during a response -> rsp_* stable, req_ready=0. A divergent SPLIT on w3 leaves w0 q_thread_mask unchanged.
- Assert rst in PUSH_FT -> next cycle rsp_valid=0, all sp=0, req_ready=1 after release.
